seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Multiplexed 4-digit seven-segment display driver for the calculator datapath. It is the output-side counterpart of the keypad column scanner: it drives active-low anodes one digit at a time and presents the matching active-low segment pattern. A 16-bit hex display buffer is loaded whole or built up one keypad digit at a time. It sits between the calculator core/keypad decoder and the board display pins.

## Interface

Parameters:
- DIGIT_TICKS, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be at least 4.
- BLANK_TICKS, 2000: cycles at the start of each slot with all anodes off (anti-ghosting); must be at least 1 and less than DIGIT_TICKS.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- load, input, 1: single-cycle strobe. Copies `value` into the buffer.
- value, input, 16: four hex digits. [3:0] is the rightmost digit.
- push, input, 1: single-cycle strobe. Shifts the buffer left by 4 bits and inserts `digit` into [3:0].
- digit, input, 4: key code from the keypad decoder.
- clr, input, 1: single-cycle strobe. Sets the buffer to 0.
- blank_lz, input, 1: enables leading-zero blanking.
- dp_en, input, 4: decimal point enable per digit.
- an, output, 4: anodes, active-low. an[0] is the rightmost digit.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp_n, output, 1: decimal point, active-low.

## Operation

- Buffer update priority is clr > load > push. Exactly one action is taken per cycle, and the buffer is written on the same clk edge.
- A push shifts out the leftmost digit (buf[15:12]); it is discarded, with no overflow flag.
- Slot counter `cnt` runs 0 to DIGIT_TICKS-1. When it wraps, digit index `idx` advances 0→1→2→3→0.
- Blank phase is `cnt < BLANK_TICKS`: an=4'b1111, seg=7'h7F, dp_n=1.
- Drive phase: an = ~(1<<idx), seg = encode(buf[4*idx+3:4*idx]), dp_n = ~dp_en[idx].
- Leading-zero blanking: digit idx ≥ 1 is suppressed when blank_lz=1 and buf digits idx..3 are all zero. A suppressed digit keeps its anode active but drives seg=7'h7F and dp_n=1. Digit 0 is never suppressed.
- Encoding (active-low gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Values on `value` and `digit` are ignored unless their strobe is high.

## Timing

- Reset values: buf=0, cnt=0, idx=0, an=4'b1111, seg=7'h7F, dp_n=1.
- Outputs are registered from the previous cycle's cnt, idx and buf.
- Buffer-to-pin latency is 1 clk when the affected digit is in its drive phase.
- Slot boundary: cnt=DIGIT_TICKS-1 is the last drive cycle of `idx`. The next cycle starts the blank phase of idx+1.
- An update that lands during a blank phase appears at the first drive cycle of that slot.
- After rst_n deasserts, the first drive output is digit 0, starting BLANK_TICKS+1 cycles later.
- A full refresh takes 4·DIGIT_TICKS cycles.
- Reset asserted mid-slot forces all outputs to their reset values immediately (asynchronous). Scanning restarts at idx=0, cnt=0.
- Simultaneous strobes resolve by priority in one cycle. A push in the cycle right after a load shifts the loaded value.
- blank_lz and dp_en are not latched. Changes take effect at the next output register update.

## Structure

- Package `seg7_pkg` holds:
  - the 16-entry active-low encoding constant table;
  - the SEG_OFF constant (7'h7F) and AN_OFF constant (4'hF);
  - the default tick constants.
- Sub-module `hex_to_seg7` is combinational: 4-bit in, 7-bit active-low pattern out. It is instantiated once on the muxed digit.
- Top-level logic: buffer register, slot counter and index, leading-zero compare, output registers.

## Test plan

Benches use DIGIT_TICKS=8, BLANK_TICKS=1.

- Reset, then load value=16'h12AF: over one 32-cycle frame the drive phases show an=1110/seg=0E, an=1101/seg=08, an=1011/seg=24, an=0111/seg=79. Every blank cycle shows an=1111.
- After clr, push digit=3 then 7 then 9, with blank_lz=1: buf=16'h0379. Digit 3 shows seg=7F with an=0111 still active. Digits 0–2 show 10, 78, 30.
- With buf=0 and blank_lz=1: only digit 0 shows 40; the other slots show 7F. With blank_lz=0: all four show 40.
- load value=16'hFFFF, clr and push all high in the same cycle: buf=0. Then load and push in the same cycle: buf equals `value`.
- Five pushes of digits 1, 2, 3, 4, 5: buf=16'h2345 and digit 1 is dropped.
- dp_en=4'b0100 with rst_n pulsed low at cnt=5 of slot 2: outputs go 1111/7F/1 asynchronously. After release, scanning restarts at digit 0, and dp_n=0 only during digit 2's drive phase.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// active-low glyph table, idle pin levels and default scan timing.
package seg7_pkg;

    localparam int DIGIT_TICKS_DEF = 100000;
    localparam int BLANK_TICKS_DEF = 2000;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index n holds the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit to active-low seven-segment pattern lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: 16-bit hex buffer (clr > load > push),
// per-slot anti-ghost blanking, leading-zero suppression, registered active-low pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = DIGIT_TICKS_DEF,
    parameter int BLANK_TICKS = BLANK_TICKS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        push,
    input  logic [3:0]  digit,
    input  logic        clr,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int CW = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_TICKS);

    logic [15:0]   disp_q, disp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpn_q, dpn_d;

    logic [3:0]    cur_hex;
    logic [6:0]    cur_seg;
    logic          upper_zero;
    logic          suppress;

    always_comb begin
        disp_d = disp_q;
        if (clr) begin
            disp_d = 16'h0000;
        end else if (load) begin
            disp_d = value;
        end else if (push) begin
            disp_d = {disp_q[11:0], digit};
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    assign cur_hex = disp_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_enc (
        .hex_i (cur_hex),
        .seg_o (cur_seg)
    );

    // A digit is a leading zero only if it and every digit to its left are zero.
    always_comb begin
        unique case (idx_q)
            2'd1:    upper_zero = (disp_q[15:4]  == 12'h000);
            2'd2:    upper_zero = (disp_q[15:8]  == 8'h00);
            2'd3:    upper_zero = (disp_q[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    assign suppress = blank_lz & upper_zero;

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dpn_d = 1'b1;
        if (cnt_q >= CNT_BLANK) begin
            an_d = ~(4'b0001 << idx_q);
            if (!suppress) begin
                seg_d = cur_seg;
                dpn_d = ~dp_en[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= 16'h0000;
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            dpn_q  <= 1'b1;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dpn_q  <= dpn_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dpn_q;

endmodule
